matrix_frame_store: RTL and testbench
=====================================

# matrix_frame_store

Double-buffered bicolor frame store that sits directly upstream of the 8x8 red/green LED matrix scan driver. A producer writes row bytes into a back buffer over a valid/ready port and commits the frame with a last flag; the scan driver reads row bytes from the front buffer. Buffers swap only on the driver's end-of-frame pulse, so a displayed frame never tears.

## Interface
- ROWS, 8, matrix rows per colour plane
- COLS, 8, bits per row byte
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- wr_valid  in  1  producer write request
- wr_ready  out  1  store accepts a write this cycle
- wr_color  in  1  0 = red plane, 1 = green plane
- wr_row  in  $clog2(ROWS)  target row
- wr_data  in  COLS  row byte; bit n drives column n
- wr_last  in  1  final write of the frame; commits the back buffer
- rd_color  in  1  scan-side plane select
- rd_row  in  $clog2(ROWS)  scan-side row select
- rd_data  out  COLS  front-buffer byte, registered
- frame_sync  in  1  single-cycle pulse from the scan driver when the last row of the green plane has been shifted out
- swap_pending  out  1  a committed frame is waiting for frame_sync
- frame_count  out  8  number of completed swaps, wraps

## Operation
- Two banks, each holding 2 colours x ROWS x COLS bits. front_sel selects the bank the scan side reads; the other bank is the back buffer.
- States: FILL, PENDING.
- FILL: wr_ready = 1. A write is accepted when wr_valid && wr_ready and stores wr_data into back[wr_color][wr_row]. If wr_last is set on an accepted write, go to PENDING.
- PENDING: wr_ready = 0, swap_pending = 1. On frame_sync: flip front_sel, increment frame_count, go to FILL.
- frame_sync in FILL is ignored.
- frame_sync in the same cycle as the accepted wr_last write does not swap. A later pulse is required.
- After a swap the back buffer holds the previously displayed frame and is not cleared. Partial rewrites are legal.
- Rows not written in a frame keep their old back-buffer contents.
- frame_count wraps from 255 to 0.
- Reset: both banks cleared to 0, front_sel = 0, state = FILL, rd_data = 0, frame_count = 0, swap_pending = 0, wr_ready = 0 during the rst cycle and 1 from the first cycle after.
- Reset while PENDING discards the pending frame.

## Timing
- Write: data is visible in the back bank on the edge that accepts it. The earliest transition to PENDING is the following cycle.
- Read latency is 1 cycle: rd_color/rd_row sampled at edge N, rd_data valid after edge N.
- Swap: frame_sync high in cycle N while PENDING. front_sel flips at the end of N, so a read address presented in cycle N+1 returns new-frame data after edge N+1. wr_ready rises in cycle N+1.
- Reads and writes never target the same bank in the same cycle, so there is no read/write hazard.
- Throughput: one row write per cycle in FILL. A full frame is 16 writes.

## Structure
- Package matrix_pkg:
  - ROWS and COLS constants
  - row index typedef
  - colour enum (RED = 0, GREEN = 1)
  - state enum {FILL, PENDING}
- Sub-module matrix_bank: one 2 x ROWS x COLS bit store with a write-enable port and a registered read port. It is instantiated twice; front_sel steers the write enables and the read mux.
- The top level holds the FSM, front_sel, frame_count and the output mux.

## Test plan
- Reset, then read all 16 rows -> rd_data = 0x00 for every address; wr_ready = 1 one cycle after rst falls.
- Write red rows 0..7 = 0x01..0x80 and green rows 0..7 = 0xFF, with wr_last on the final write, then pulse frame_sync -> swap_pending rises the cycle after wr_last and falls after frame_sync; frame_count = 1; rd red row 3 = 0x08, green row 5 = 0xFF.
- Commit a frame with no frame_sync, then hold wr_valid for 20 cycles -> wr_ready = 0 throughout; the front buffer is still all zeros; no write is accepted.
- Assert frame_sync in the same cycle as the wr_last write, and again 5 cycles later -> no swap on the first pulse; swap on the second; frame_count increments by exactly 1.
- Assert rst while PENDING, then pulse frame_sync -> no swap; state = FILL; all reads return 0x00; frame_count = 0.
- Perform 256 commit/sync cycles -> frame_count returns to 0; front_sel alternates, checked by writing an alternating pattern of 0xAA and 0x55 to row 0.

Source files
------------

// File: rtl/matrix_pkg.sv
// rtl/matrix_pkg.sv - shared constants and types for the LED matrix frame store
package matrix_pkg;

    localparam int ROWS     = 8;
    localparam int COLS     = 8;
    localparam int ROW_W    = $clog2(ROWS);
    localparam int ADDR_W   = ROW_W + 1;
    localparam int CNT_W    = 8;

    typedef logic [ROW_W-1:0] row_t;

    typedef enum logic {
        RED   = 1'b0,
        GREEN = 1'b1
    } color_t;

    typedef enum logic {
        FILL    = 1'b0,
        PENDING = 1'b1
    } state_t;

    // Flat bank address: colour plane in the MSB, row below it.
    function automatic logic [ADDR_W-1:0] bank_addr(input logic color, input row_t row);
        return {color, row};
    endfunction

endpackage

// File: rtl/matrix_bank.sv
// rtl/matrix_bank.sv - one 2 x ROWS x COLS bit store with write port and registered read port
module matrix_bank
    import matrix_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            we,
    input  logic            wr_color,
    input  row_t            wr_row,
    input  logic [COLS-1:0] wr_data,
    input  logic            rd_color,
    input  row_t            rd_row,
    output logic [COLS-1:0] rd_data
);

    logic [COLS-1:0] mem [2*ROWS];

    // Clear on reset; otherwise write when enabled and always register the read.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 2*ROWS; i++) begin
                mem[i] <= '0;
            end
            rd_data <= '0;
        end else begin
            if (we) begin
                mem[bank_addr(wr_color, wr_row)] <= wr_data;
            end
            rd_data <= mem[bank_addr(rd_color, rd_row)];
        end
    end

endmodule

// File: rtl/matrix_frame_store.sv
// rtl/matrix_frame_store.sv - double-buffered bicolor frame store swapping on scan end-of-frame
module matrix_frame_store
    import matrix_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_valid,
    output logic             wr_ready,
    input  logic             wr_color,
    input  row_t             wr_row,
    input  logic [COLS-1:0]  wr_data,
    input  logic             wr_last,
    input  logic             rd_color,
    input  row_t             rd_row,
    output logic [COLS-1:0]  rd_data,
    input  logic             frame_sync,
    output logic             swap_pending,
    output logic [CNT_W-1:0] frame_count
);

    state_t          state;
    state_t          state_next;
    logic            front_sel;
    logic            rd_sel_q;
    logic            swap;
    logic            wr_en;
    logic [COLS-1:0] bank0_rd;
    logic [COLS-1:0] bank1_rd;

    // Next-state and handshake decode; frame_sync only matters once a frame is committed.
    always_comb begin
        state_next   = state;
        wr_ready     = 1'b0;
        swap_pending = 1'b0;
        swap         = 1'b0;
        wr_en        = 1'b0;
        case (state)
            FILL: begin
                wr_ready = !rst;
                wr_en    = wr_valid && !rst;
                if (wr_en && wr_last) begin
                    state_next = PENDING;
                end
            end
            PENDING: begin
                swap_pending = 1'b1;
                if (frame_sync) begin
                    swap       = 1'b1;
                    state_next = FILL;
                end
            end
            default: state_next = FILL;
        endcase
    end

    // State, bank selection and swap counter. rd_sel_q tracks which bank the
    // registered read came from so the output never mixes banks across a swap.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= FILL;
            front_sel   <= 1'b0;
            rd_sel_q    <= 1'b0;
            frame_count <= '0;
        end else begin
            state    <= state_next;
            rd_sel_q <= front_sel;
            if (swap) begin
                front_sel   <= ~front_sel;
                frame_count <= frame_count + 1'b1;
            end
        end
    end

    matrix_bank u_bank0 (
        .clk      (clk),
        .rst      (rst),
        .we       (wr_en && front_sel),
        .wr_color (wr_color),
        .wr_row   (wr_row),
        .wr_data  (wr_data),
        .rd_color (rd_color),
        .rd_row   (rd_row),
        .rd_data  (bank0_rd)
    );

    matrix_bank u_bank1 (
        .clk      (clk),
        .rst      (rst),
        .we       (wr_en && !front_sel),
        .wr_color (wr_color),
        .wr_row   (wr_row),
        .wr_data  (wr_data),
        .rd_color (rd_color),
        .rd_row   (rd_row),
        .rd_data  (bank1_rd)
    );

    assign rd_data = rd_sel_q ? bank1_rd : bank0_rd;

endmodule

// File: tb/tb_matrix_frame_store.sv
// tb/tb_matrix_frame_store.sv - directed self-checking bench for matrix_frame_store
module tb_matrix_frame_store;
    import matrix_pkg::*;

    logic             clk = 1'b0;
    logic             rst;
    logic             wr_valid;
    logic             wr_ready;
    logic             wr_color;
    row_t             wr_row;
    logic [COLS-1:0]  wr_data;
    logic             wr_last;
    logic             rd_color;
    row_t             rd_row;
    logic [COLS-1:0]  rd_data;
    logic             frame_sync;
    logic             swap_pending;
    logic [CNT_W-1:0] frame_count;

    int n_checks = 0;
    int n_errors = 0;

    matrix_frame_store dut (
        .clk          (clk),
        .rst          (rst),
        .wr_valid     (wr_valid),
        .wr_ready     (wr_ready),
        .wr_color     (wr_color),
        .wr_row       (wr_row),
        .wr_data      (wr_data),
        .wr_last      (wr_last),
        .rd_color     (rd_color),
        .rd_row       (rd_row),
        .rd_data      (rd_data),
        .frame_sync   (frame_sync),
        .swap_pending (swap_pending),
        .frame_count  (frame_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        check("wr_ready_in_rst", wr_ready, 0);
        tick();
        rst = 1'b0;
        #1;
    endtask

    task automatic write_row(input logic color, input int row, input logic [7:0] data, input logic last);
        wr_valid = 1'b1;
        wr_color = color;
        wr_row   = row_t'(row);
        wr_data  = data;
        wr_last  = last;
        tick();
        wr_valid = 1'b0;
        wr_last  = 1'b0;
    endtask

    task automatic read_row(input logic color, input int row, output logic [7:0] data);
        rd_color = color;
        rd_row   = row_t'(row);
        tick();
        data = rd_data;
    endtask

    task automatic pulse_sync();
        frame_sync = 1'b1;
        tick();
        frame_sync = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        logic [7:0] d;
        for (int c = 0; c < 2; c++) begin
            for (int r = 0; r < ROWS; r++) begin
                read_row(c[0], r, d);
                check(tag, d, 8'h00);
            end
        end
    endtask

    initial begin
        logic [7:0] d;
        logic [7:0] pat;

        rst = 1'b1; wr_valid = 1'b0; wr_color = 1'b0; wr_row = '0; wr_data = '0;
        wr_last = 1'b0; rd_color = 1'b0; rd_row = '0; frame_sync = 1'b0;

        // Reset state
        do_reset();
        check("wr_ready_after_rst", wr_ready, 1);
        check("swap_pending_rst", swap_pending, 0);
        check("frame_count_rst", frame_count, 0);
        check_all_zero("rst_read");

        // Full frame: red one-hot rows, green all ones
        for (int r = 0; r < ROWS; r++) write_row(1'b0, r, 8'h01 << r, 1'b0);
        for (int r = 0; r < ROWS; r++) write_row(1'b1, r, 8'hFF, r == ROWS-1);
        check("pending_after_last", swap_pending, 1);
        check("ready_low_pending", wr_ready, 0);
        check("count_before_sync", frame_count, 0);
        pulse_sync();
        check("pending_after_sync", swap_pending, 0);
        check("ready_after_sync", wr_ready, 1);
        check("count_after_sync", frame_count, 1);
        read_row(1'b0, 3, d); check("red_row3", d, 8'h08);
        read_row(1'b1, 5, d); check("green_row5", d, 8'hFF);
        read_row(1'b0, 0, d); check("red_row0", d, 8'h01);
        read_row(1'b0, 7, d); check("red_row7", d, 8'h80);

        // Committed frame with no sync blocks further writes
        do_reset();
        write_row(1'b0, 0, 8'h11, 1'b1);
        wr_valid = 1'b1; wr_color = 1'b0; wr_row = row_t'(1); wr_data = 8'h99; wr_last = 1'b1;
        for (int i = 0; i < 20; i++) begin
            check("ready_held_low", wr_ready, 0);
            tick();
        end
        wr_valid = 1'b0; wr_last = 1'b0;
        read_row(1'b0, 0, d); check("front_still_zero_r0", d, 8'h00);
        read_row(1'b0, 1, d); check("front_still_zero_r1", d, 8'h00);
        pulse_sync();
        check("count_blocked_sync", frame_count, 1);
        read_row(1'b0, 0, d); check("blocked_new_r0", d, 8'h11);
        read_row(1'b0, 1, d); check("blocked_no_write_r1", d, 8'h00);

        // frame_sync coincident with wr_last does not swap
        frame_sync = 1'b1;
        write_row(1'b0, 2, 8'h5A, 1'b1);
        frame_sync = 1'b0;
        check("coincident_pending", swap_pending, 1);
        check("coincident_count", frame_count, 1);
        for (int i = 0; i < 4; i++) tick();
        check("still_pending", swap_pending, 1);
        pulse_sync();
        check("second_pulse_count", frame_count, 2);
        check("second_pulse_pending", swap_pending, 0);
        read_row(1'b0, 2, d); check("coinc_new_r2", d, 8'h5A);
        read_row(1'b0, 0, d); check("untouched_row_kept", d, 8'h00);

        // Reset while pending discards the frame
        write_row(1'b0, 4, 8'h3C, 1'b1);
        check("pending_before_rst", swap_pending, 1);
        do_reset();
        pulse_sync();
        check("rst_pending_cleared", swap_pending, 0);
        check("rst_fill_ready", wr_ready, 1);
        check("rst_count_zero", frame_count, 0);
        check_all_zero("rst_pending_read");

        // 256 commit/sync cycles with alternating row 0 pattern
        for (int i = 0; i < 256; i++) begin
            pat = (i % 2 == 0) ? 8'hAA : 8'h55;
            write_row(1'b0, 0, pat, 1'b1);
            pulse_sync();
            read_row(1'b0, 0, d);
            check("alt_row0", d, pat);
            if (i == 254) check("count_255", frame_count, 255);
        end
        check("count_wrapped", frame_count, 0);
        check("wrap_no_pending", swap_pending, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
